// File: rtl/fnd_watch_disp_pkg.sv
// Shared constants for the watch FND display path.
// Field codes, segment patterns and decimal split helper.
package fnd_watch_disp_pkg;

    localparam logic [1:0] FIELD_MSEC = 2'd0;
    localparam logic [1:0] FIELD_SEC  = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_HOUR = 2'd3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] DP_MASK   = 8'h7F;

    localparam logic [3:0] CODE_DASH = 4'd10;

    // Active-low {dp,g,f,e,d,c,b,a}; element 0 is digit '0'.
    localparam logic [9:0][7:0] SEG_DIGITS = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Returns {tens, ones}; tens may exceed 9 for out-of-range input.
    function automatic logic [7:0] split_dec(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/fnd_watch_disp_bcd_to_seg.sv
// Digit code to active-low segment pattern.
// Codes 0..9 are digits, 10 is a dash, anything else is blank.
import fnd_watch_disp_pkg::*;

module bcd_to_seg (
    input  logic [3:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (code < 4'd10)
            seg = SEG_DIGITS[code];
        else if (code == CODE_DASH)
            seg = SEG_DASH;
    end

endmodule

// File: rtl/fnd_watch_disp.sv
// Time-multiplexed 4-digit FND driver for the watch datapath.
// Frame-consistent snapshot, view select and edit-field blinking.
import fnd_watch_disp_pkg::*;

module fnd_watch_disp #(
    parameter int SCAN_COUNT  = 100_000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic       disp_mode,
    input  logic       edit_en,
    input  logic [1:0] time_select,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [SW-1:0] scan_cnt;
    logic          scan_tick;
    logic [1:0]    idx;

    logic [6:0]    snap_msec;
    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [4:0]    snap_hour;
    logic          snap_mode;

    logic [BW-1:0] blink_cnt;
    logic          blink_off;
    logic          edit_q;
    logic [1:0]    sel_q;
    logic          edit_chg;

    logic [6:0]    pair_val;
    logic [7:0]    split;
    logic [3:0]    code;
    logic [1:0]    field;
    logic          blank;
    logic          dp_on;
    logic [7:0]    seg_raw;
    logic [7:0]    seg_out;

    assign scan_tick = (scan_cnt == SW'(SCAN_COUNT - 1));
    assign edit_chg  = (edit_en != edit_q) || (time_select != sel_q);

    always_comb begin
        pair_val = snap_msec;
        field    = FIELD_MSEC;
        unique case (1'b1)
            ( snap_mode &&  idx[1]): begin
                pair_val = {2'b0, snap_hour};
                field    = FIELD_HOUR;
            end
            ( snap_mode && !idx[1]): begin
                pair_val = {1'b0, snap_min};
                field    = FIELD_MIN;
            end
            (!snap_mode &&  idx[1]): begin
                pair_val = {1'b0, snap_sec};
                field    = FIELD_SEC;
            end
            default: begin
                pair_val = snap_msec;
                field    = FIELD_MSEC;
            end
        endcase
    end

    assign split = split_dec(pair_val);
    assign code  = !idx[0]               ? split[3:0] :
                   (split[7:4] > 4'd9)   ? CODE_DASH  :
                                           split[7:4];

    bcd_to_seg u_seg (
        .code (code),
        .seg  (seg_raw)
    );

    // Separator dot sits on digit 2; in sec:msec view it pulses at 1 Hz.
    assign dp_on = (idx == 2'd2) && (snap_mode || (snap_msec < 7'd50));
    assign blank = edit_en && blink_off && (field == time_select);

    assign seg_out = blank ? SEG_BLANK :
                     dp_on ? (seg_raw & DP_MASK) :
                             seg_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt  <= '0;
            idx       <= 2'd0;
            fnd_com   <= 4'b1111;
            fnd_data  <= SEG_BLANK;
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
            snap_mode <= 1'b0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
            if (scan_tick) begin
                idx      <= idx + 2'd1;
                fnd_com  <= ~(4'b0001 << idx);
                fnd_data <= seg_out;
                if (idx == 2'd3) begin
                    snap_msec <= msec;
                    snap_sec  <= sec;
                    snap_min  <= min;
                    snap_hour <= hour;
                    snap_mode <= disp_mode;
                end
            end
        end
    end

    // Edit changes restart the blink so the new field shows at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
            edit_q    <= 1'b0;
            sel_q     <= 2'd0;
        end else begin
            edit_q <= edit_en;
            sel_q  <= time_select;
            if (edit_chg) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (scan_tick) begin
                if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_watch_disp.sv
// Directed bench for fnd_watch_disp with SCAN_COUNT=4, BLINK_TICKS=4.
// Outputs are sampled on the falling edge, indexed by rising edges since reset release.
module tb_fnd_watch_disp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic       disp_mode = 1'b0;
    logic       edit_en = 1'b0;
    logic [1:0] time_select = 2'd0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int n_vec = 0;
    int n_bad = 0;
    int edges;

    fnd_watch_disp #(
        .SCAN_COUNT  (4),
        .BLINK_TICKS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .msec        (msec),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .disp_mode   (disp_mode),
        .edit_en     (edit_en),
        .time_select (time_select),
        .fnd_com     (fnd_com),
        .fnd_data    (fnd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst)
        if (!rst) edges <= 0;
        else      edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic at(input int k);
        int guard = 0;
        while (edges < k && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("sync@%0d", k), edges, k);
    endtask

    // Output registered at edge 4n shows digit (n-1) mod 4.
    task automatic dig(input int k, input logic [7:0] data);
        logic [3:0] com;
        com = ~(4'b0001 << ((k / 4 - 1) % 4));
        at(k);
        chk($sformatf("com@%0d", k), fnd_com, com);
        chk($sformatf("data@%0d", k), fnd_data, data);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_com", fnd_com, 4'hF);
        chk("rst_data", fnd_data, 8'hFF);
        rst = 1'b1;

        at(1);
        chk("pre_com1", fnd_com, 4'hF);
        chk("pre_data1", fnd_data, 8'hFF);
        at(3);
        chk("pre_com3", fnd_com, 4'hF);
        chk("pre_data3", fnd_data, 8'hFF);

        sec  = 6'd42;
        msec = 7'd37;
        // First frame shows the all-zero reset snapshot.
        dig(4,  8'hC0);
        dig(8,  8'hC0);
        dig(12, 8'h40);
        dig(16, 8'hC0);

        // Mode 0: 42.37
        dig(20, 8'hF8);
        hour      = 5'd12;
        min       = 6'd5;
        disp_mode = 1'b1;
        dig(24, 8'hB0);
        dig(28, 8'h24);
        dig(32, 8'h99);

        // Mode 1: 12.05
        dig(36, 8'h92);
        dig(40, 8'hC0);
        dig(44, 8'h24);
        dig(48, 8'hF9);
        disp_mode = 1'b0;
        msec      = 7'd120;

        // msec=120 -> dash tens, no dot
        dig(68, 8'hC0);
        dig(72, 8'hBF);
        msec = 7'd37;
        dig(76, 8'hA4);
        dig(80, 8'h99);
        dig(84, 8'hF8);

        disp_mode   = 1'b1;
        edit_en     = 1'b1;
        time_select = 2'd2;
        dig(100, 8'h92);
        dig(104, 8'hFF);
        dig(108, 8'h24);
        dig(112, 8'hF9);
        dig(116, 8'hFF);
        dig(120, 8'hC0);
        dig(132, 8'h92);
        dig(136, 8'hFF);

        time_select = 2'd3;
        dig(140, 8'h24);
        dig(144, 8'hF9);
        dig(148, 8'h92);
        dig(152, 8'hC0);
        dig(156, 8'hFF);
        dig(160, 8'hFF);
        dig(164, 8'h92);

        rst = 1'b0;
        #1;
        chk("midrst_com", fnd_com, 4'hF);
        chk("midrst_data", fnd_data, 8'hFF);
        @(negedge clk);
        rst = 1'b1;
        at(3);
        chk("rel_com3", fnd_com, 4'hF);
        chk("rel_data3", fnd_data, 8'hFF);
        dig(4, 8'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
